// File: rtl/atari7800_pkg.sv
// Shared types and constants for the Atari 7800 CPU-side bus logic.
package atari7800_pkg;

    // Bus arbitration states seen from the 6502 side.
    typedef enum logic [1:0] {
        RUN,
        HALT_REQ,
        HALTED,
        RESUME
    } arb_state_t;

    // Number of real cpu_ce pulses a stretched NMI is held across.
    localparam int NMI_HOLD_CE = 2;

endpackage

// File: rtl/nmi_stretch.sv
// Stretches a falling edge of the video chip's NMI so the edge-sensitive
// 6502 core sees it held across NMI_HOLD_CE real CPU clock enables.
module nmi_stretch
    import atari7800_pkg::*;
(
    input  logic clk_sys,
    input  logic reset_n,
    input  logic nmi_n,
    input  logic cpu_ce,
    output logic cpu_nmi_n
);

    localparam logic [1:0] LAST_CE = 2'(NMI_HOLD_CE - 1);

    logic       nmi_q;
    logic [1:0] ce_cnt;

    // Edge detect on nmi_n; hold cpu_nmi_n low until the counted cpu_ce.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            nmi_q     <= 1'b1;
            ce_cnt    <= '0;
            cpu_nmi_n <= 1'b1;
        end else begin
            nmi_q <= nmi_n;
            if (nmi_q && !nmi_n) begin
                // A fresh edge (re)starts the hold, even mid-hold.
                cpu_nmi_n <= 1'b0;
                ce_cnt    <= '0;
            end else if (!cpu_nmi_n && cpu_ce) begin
                if (ce_cnt == LAST_CE) begin
                    cpu_nmi_n <= 1'b1;
                    ce_cnt    <= '0;
                end else begin
                    ce_cnt <= ce_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// CPU-side responder to the video chip's HALT / READY / NMI requests.
// Generates the 6502 clock enable from the phase strobes, honours HALT only
// at read-cycle boundaries, hands the bus over with a turnaround slot and
// stretches NMI.
// Optional: define CPU_ARB_STATS_EN to add halt_count / stall_cycles ports.
module cpu_bus_arbiter
    import atari7800_pkg::*;
#(
    parameter int MAX_WRITES = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        pclk0,
    input  logic        pclk1,
    input  logic        halt_n,
    input  logic        ready,
    input  logic        nmi_n,
    input  logic        cpu_rw,
    output logic        cpu_ce,
    output logic        cpu_nmi_n,
    output logic        bus_grant,
    output logic        cpu_drive_ab,
    output logic        protocol_err
`ifdef CPU_ARB_STATS_EN
    ,
    output logic [15:0] halt_count,
    output logic [15:0] stall_cycles
`endif
);

    localparam logic [1:0] WR_MAX = 2'(MAX_WRITES);

    arb_state_t state;
    logic [1:0] wr_cnt;
    logic       stall_pending;
    logic       resume_slot;   // turnaround slot of RESUME already spent
    logic       halt_again;    // HALT re-requested while resuming
    logic       armed;
    logic       p0;
    logic       p1;

    // Strobes coincident with reset release are dropped until armed.
    assign p0 = pclk0 && armed;
    assign p1 = pclk1 && armed;

    // Arm the strobe inputs one clk after reset deassertion.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) armed <= 1'b0;
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        else          armed <= 1'b1;
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RUN;
            wr_cnt        <= '0;
            stall_pending <= 1'b0;
            resume_slot   <= 1'b0;
            halt_again    <= 1'b0;
            cpu_ce        <= 1'b0;
            bus_grant     <= 1'b0;
            cpu_drive_ab  <= 1'b1;
            protocol_err  <= 1'b0;
        end else begin
            // NOTE: cpu_ce defaults low each clk so any pulse is exactly one clk wide.
            cpu_ce <= 1'b0;
            case (state)
                RUN: begin
                    wr_cnt <= '0;
                    if (p0) begin
                        cpu_ce        <= !stall_pending;
                        stall_pending <= 1'b0;
                    end
                    if (p1) begin
                        if (!halt_n) begin
                            // HALT wins over a simultaneous ready-stall.
                            stall_pending <= 1'b0;
                            if (cpu_rw) begin
                                state <= HALTED;
                            end else begin
                                state  <= HALT_REQ;
                                wr_cnt <= 2'd1;
                            end
                        end else if (!ready && cpu_rw) begin
                            stall_pending <= 1'b1;
                        end
                    end
                end
                HALT_REQ: begin
                    if (p0) cpu_ce <= 1'b1;
                    if (p1) begin
                        if (halt_n) begin
                            state         <= RUN;
                            wr_cnt        <= '0;
                            stall_pending <= !ready && cpu_rw;
                        end else if (cpu_rw) begin
                            state  <= HALTED;
                            wr_cnt <= '0;
                        end else if (wr_cnt == WR_MAX) begin
                            protocol_err <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + 2'd1;
                        end
                    end
                end
                HALTED: begin
                    if (p0) begin
                        bus_grant    <= 1'b1;
                        cpu_drive_ab <= 1'b0;
                    end
                    if (p1 && halt_n) begin
                        state       <= RESUME;
                        resume_slot <= 1'b0;
                        halt_again  <= 1'b0;
                    end
                end
                RESUME: begin
                    if (p0) begin
                        if (!resume_slot) begin
                            bus_grant   <= 1'b0;
                            resume_slot <= 1'b1;
                        end else begin
                            cpu_drive_ab <= 1'b1;
                            cpu_ce       <= 1'b1;
                            resume_slot  <= 1'b0;
                            state        <= halt_again ? HALT_REQ : RUN;
                        end
                    end
                    if (p1 && !halt_n) halt_again <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef CPU_ARB_STATS_EN
    logic halt_entry;
    logic stall_slot;

    assign halt_entry = p1 && !halt_n && cpu_rw &&
                        (state == RUN || state == HALT_REQ);
    assign stall_slot = p0 && ((state == RUN && stall_pending) ||
                               state == HALTED ||
                               (state == RESUME && !resume_slot));

    // Halt entry counter (wraps) and suppressed-slot counter (saturates).
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            halt_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (halt_entry) halt_count <= halt_count + 16'd1;
            if (stall_slot && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

    nmi_stretch u_nmi_stretch (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .nmi_n     (nmi_n),
        .cpu_ce    (cpu_ce),
        .cpu_nmi_n (cpu_nmi_n)
    );

endmodule
